rtp_touch_ctrl: RTL

Sequencer for the RTP SPI byte engine attached to the AR1021 resistive touch controller. Polls the panel at a fixed interval, issues dummy bytes through RTP with the AR1021 inter-byte gap enforced in hardware, and assembles the 5-byte touch report into latched 12-bit X/Y coordinates plus a pen flag. Sits between RTP and the memory-mapped IO bus, replacing the software polling/delay loop.

---
 rtl/rtp_pkg.sv | 23 ++
 rtl/rtp_delay.sv | 27 ++
 rtl/rtp_touch_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rtp_pkg.sv
// Shared types and constants for the AR1021 touch sequencer.
// Report framing: one header byte followed by four 7-bit payload bytes.
package rtp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_WAIT,
    S_LOAD,
    S_ARM,
    S_XFER,
    S_GAP
  } state_t;

  localparam int         REPORT_BYTES = 5;
  localparam logic [7:0] HDR_MASK     = 8'h80;
  localparam int         PEN_BIT      = 0;
  localparam logic [7:0] DUMMY_BYTE   = 8'h00;

  function automatic logic flag_set(input logic [7:0] b);
    return (b & HDR_MASK) != 8'h00;
  endfunction

endpackage

// File: rtl/rtp_delay.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared by the poll interval and the inter-byte gap.
module rtp_delay #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rtp_touch_ctrl.sv
// AR1021 polling sequencer: drives dummy bytes through RTP and
// assembles the 5-byte touch report into latched X/Y/pen.
module rtp_touch_ctrl
  import rtp_pkg::*;
#(
  parameter int GAP_CYCLES  = 1250,
  parameter int POLL_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        rtp_load,
  output logic [15:0] rtp_in,
  input  logic [15:0] rtp_out,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        pen,
  output logic        valid,
  output logic        err,
  output logic        active
);

  localparam int MAXP = (GAP_CYCLES > POLL_CYCLES) ?
                        GAP_CYCLES : POLL_CYCLES;
  localparam int CWR  = $clog2(MAXP) + 1;
  localparam int CW   = (CWR < 17) ? 17 : CWR;

  localparam logic [CW-1:0] POLL_RLD = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RLD  = CW'(GAP_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST = 3'(REPORT_BYTES - 1);

  state_t      state;
  state_t      nxt;
  logic        busy;
  logic [7:0]  rx;
  logic        unused_bits;
  logic [2:0]  idx;
  logic        rej;
  logic        last;
  logic        take;
  logic        adv;
  logic        dly_load;
  logic        dly_done;
  logic [CW-1:0] dly_val;

  logic        pen_s;
  logic [6:0]  x_lo;
  logic [4:0]  x_hi;
  logic [6:0]  y_lo;

  assign busy        = rtp_out[15];
  assign rx          = rtp_out[7:0];
  assign unused_bits = ^rtp_out[14:8];
  assign rtp_in      = {8'h00, DUMMY_BYTE};
  assign last        = (idx == IDX_LAST);

  rtp_delay #(.W(CW)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (dly_load),
    .load_val (dly_val),
    .done     (dly_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    dly_load = 1'b0;
    dly_val  = POLL_RLD;
    rtp_load = 1'b0;
    take     = 1'b0;
    adv      = 1'b0;
    active   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && !busy) begin
          nxt      = S_POLL_WAIT;
          dly_load = 1'b1;
        end
      end
      S_POLL_WAIT: begin
        if (!enable)       nxt = S_IDLE;
        else if (dly_done) nxt = S_LOAD;
      end
      S_LOAD: begin
        active = 1'b1;
        // never pulse a load into a still-busy engine
        if (!busy) begin
          rtp_load = 1'b1;
          nxt      = S_ARM;
        end
      end
      S_ARM: begin
        active = 1'b1;
        nxt    = S_XFER;
      end
      S_XFER: begin
        active = 1'b1;
        if (!busy) begin
          take     = 1'b1;
          nxt      = S_GAP;
          dly_load = 1'b1;
          dly_val  = GAP_RLD;
        end
      end
      S_GAP: begin
        active = 1'b1;
        if (dly_done) begin
          if (rej || last) begin
            if (enable) begin
              nxt      = S_POLL_WAIT;
              dly_load = 1'b1;
            end else begin
              nxt = S_IDLE;
            end
          end else begin
            nxt = S_LOAD;
            adv = 1'b1;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      rej   <= 1'b0;
      pen_s <= 1'b0;
      x_lo  <= '0;
      x_hi  <= '0;
      y_lo  <= '0;
      x     <= '0;
      y     <= '0;
      pen   <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (state == S_POLL_WAIT) begin
        idx <= '0;
        rej <= 1'b0;
      end
      if (adv) idx <= idx + 3'd1;
      if (take) begin
        unique case (1'b1)
          (idx == 3'd0) && !flag_set(rx): begin
            rej <= 1'b1;
          end
          (idx != 3'd0) && flag_set(rx): begin
            rej <= 1'b1;
            err <= 1'b1;
          end
          default: begin
            case (idx)
              3'd0: pen_s <= rx[PEN_BIT];
              3'd1: x_lo  <= rx[6:0];
              3'd2: x_hi  <= rx[4:0];
              3'd3: y_lo  <= rx[6:0];
              3'd4: begin
                x     <= {x_hi, x_lo};
                y     <= {rx[4:0], y_lo};
                pen   <= pen_s;
                valid <= 1'b1;
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule
